// File: rtl/secuenciador_alu_pkg.sv
// Shared definitions for the ALU command sequencer: condition codes,
// FSM states and flag bit positions.
package secuenciador_pkg;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_MI = 3'd3;
  localparam logic [2:0] COND_PL = 3'd4;
  localparam logic [2:0] COND_VS = 3'd5;
  localparam logic [2:0] COND_VC = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/secuenciador_alu_evaluador.sv
// Combinational condition-code evaluator against stored {Z,N,V} flags;
// kept standalone so a branch unit can reuse it.
module evaluador_condicion
  import secuenciador_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_AL: pass = 1'b1;
      COND_EQ: pass = flags[FLAG_Z];
      COND_NE: pass = ~flags[FLAG_Z];
      COND_MI: pass = flags[FLAG_N];
      COND_PL: pass = ~flags[FLAG_N];
      COND_VS: pass = flags[FLAG_V];
      COND_VC: pass = ~flags[FLAG_V];
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/secuenciador_alu.sv
// ALU command sequencer: accepts one predicated command, drives the ALU,
// waits ALU_LAT cycles, captures result/status and returns a response.
module secuenciador_alu
  import secuenciador_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_cond,
  input  logic             cmd_setf,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_skip,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int unsigned CW = $clog2(ALU_LAT + 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic           setf_q;
  logic           cond_pass;
  logic           take_exec;
  logic           take_skip;
  logic           finish;

  evaluador_condicion u_eval (
    .cond  (cmd_cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    take_exec = 1'b0;
    take_skip = 1'b0;
    finish    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cond_pass) begin
            take_exec = 1'b1;
            state_n   = ST_EXEC;
          end else begin
            take_skip = 1'b1;
            state_n   = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt == '0) begin
          finish  = 1'b1;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // Counter is loaded with ALU_LAT and the result is taken on the edge
  // after it has reached zero, i.e. ALU_LAT+1 edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      setf_q   <= 1'b0;
      cnt      <= '0;
      rsp_s    <= '0;
      rsp_skip <= 1'b0;
      flags    <= '0;
    end else begin
      if (take_exec) begin
        alu_op <= cmd_op;
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
        setf_q <= cmd_setf;
        cnt    <= CW'(ALU_LAT);
      end
      if (take_skip) begin
        rsp_s    <= '0;
        rsp_skip <= 1'b1;
      end
      if (state == ST_EXEC && !finish) cnt <= cnt - CW'(1);
      if (finish) begin
        rsp_s    <= alu_s;
        rsp_skip <= 1'b0;
        if (setf_q) begin
          flags[FLAG_Z] <= alu_zero;
          flags[FLAG_N] <= alu_neg;
          flags[FLAG_V] <= alu_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_alu.sv
// Scoreboard bench for secuenciador_alu: two instances (ALU_LAT=1 and 3)
// share one scenario list; a behavioural ALU feeds each instance.
module tb_secuenciador_alu;
  import secuenciador_pkg::*;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;

  typedef struct {
    logic [31:0] s;
    logic        skip;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst       [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [3:0]  cmd_op    [2];
  logic [31:0] cmd_a     [2];
  logic [31:0] cmd_b     [2];
  logic [2:0]  cmd_cond  [2];
  logic        cmd_setf  [2];
  logic [3:0]  alu_op    [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_s     [2];
  logic        rsp_skip  [2];
  logic [2:0]  flags     [2];
  logic        busy      [2];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        sb[$];
  logic [2:0]  mflags [2];
  logic [31:0] last_a [2];
  logic [3:0]  last_op[2];

  function automatic logic [34:0] alu_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] s;
    logic v;
    v = 1'b0;
    case (op)
      4'd0: begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
      4'd1: begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
      4'd2: s = a & b;
      default: s = a | b;
    endcase
    return {s, (s == 32'd0), s[31], v};
  endfunction

  function automatic logic cond_model(input logic [2:0] c, input logic [2:0] f);
    logic z, n, v;
    z = f[2]; n = f[1]; v = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return v;
      3'd6: return !v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] s;
    logic        z, n, v;
    assign {s, z, n, v} = alu_model(alu_op[g], alu_a[g], alu_b[g]);

    secuenciador_alu #(
      .WIDTH   (32),
      .OPW     (4),
      .ALU_LAT ((g == 0) ? 1 : 3)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_a     (cmd_a[g]),
      .cmd_b     (cmd_b[g]),
      .cmd_cond  (cmd_cond[g]),
      .cmd_setf  (cmd_setf[g]),
      .alu_op    (alu_op[g]),
      .alu_a     (alu_a[g]),
      .alu_b     (alu_b[g]),
      .alu_s     (s),
      .alu_zero  (z),
      .alu_neg   (n),
      .alu_ovf   (v),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_s     (rsp_s[g]),
      .rsp_skip  (rsp_skip[g]),
      .flags     (flags[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Drives one command, records its expected response and leaves at T+#1.
  task automatic send(input int d, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] cond, input logic setf);
    exp_t e;
    logic [34:0] r;
    logic pass;
    int n = 0;
    while (!cmd_ready[d] && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (cmd_ready[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_wait[%0d]: got %b, required 1", d, cmd_ready[d]);
    end
    pass = cond_model(cond, mflags[d]);
    if (pass) begin
      r = alu_model(op, a, b);
      e.s = r[34:3];
      e.skip = 1'b0;
      if (setf) mflags[d] = r[2:0];
      e.lat = lat_of(d) + 1;
      last_a[d] = a;
      last_op[d] = op;
    end else begin
      e.s = 32'd0;
      e.skip = 1'b1;
      e.lat = 0;
    end
    e.flags = mflags[d];
    sb.push_back(e);
    cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b; cmd_cond[d] = cond; cmd_setf[d] = setf;
    cmd_valid[d] = 1'b1;
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
    vectors++;
    if (alu_a[d] !== last_a[d] || alu_op[d] !== last_op[d]) begin
      miscompares++;
      $display("FAIL alu_drive[%0d]: got op=%0d a=%h, required op=%0d a=%h",
               d, alu_op[d], alu_a[d], last_op[d], last_a[d]);
    end
  endtask

  // Waits for the response, checks it against the scoreboard, optionally
  // stalls for 'stall' cycles, then completes the handshake.
  task automatic collect(input int d, input int stall);
    exp_t e;
    int n = 0;
    logic [31:0] held;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL scoreboard_empty[%0d]: got empty queue, required entry", d);
      return;
    end
    e = sb.pop_front();
    while (!rsp_valid[d] && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (rsp_valid[d] !== 1'b1) begin
      miscompares++;
      $display("FAIL rsp_timeout[%0d]: got no rsp_valid after %0d edges, required %0d", d, n, e.lat);
      return;
    end
    if (n != e.lat || rsp_s[d] !== e.s || rsp_skip[d] !== e.skip || flags[d] !== e.flags) begin
      miscompares++;
      $display("FAIL rsp[%0d]: got lat=%0d s=%h skip=%b flags=%b, required lat=%0d s=%h skip=%b flags=%b",
               d, n, rsp_s[d], rsp_skip[d], flags[d], e.lat, e.s, e.skip, e.flags);
    end
    held = rsp_s[d];
    if (stall > 0) begin
      cmd_op[d] = OP_ADD; cmd_a[d] = 32'hDEAD_0001; cmd_b[d] = 32'd1;
      cmd_cond[d] = COND_AL; cmd_setf[d] = 1'b1; cmd_valid[d] = 1'b1;
    end
    repeat (stall) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid[d] !== 1'b1 || rsp_s[d] !== held || cmd_ready[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b s=%h ready=%b, required valid=1 s=%h ready=0",
                 d, rsp_valid[d], rsp_s[d], cmd_ready[d], held);
      end
    end
    cmd_valid[d] = 1'b0;
    if (stall > 0) begin
      vectors++;
      if (alu_a[d] !== last_a[d] || flags[d] !== mflags[d]) begin
        miscompares++;
        $display("FAIL stall_no_accept[%0d]: got a=%h flags=%b, required a=%h flags=%b",
                 d, alu_a[d], flags[d], last_a[d], mflags[d]);
      end
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    vectors++;
    if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_release[%0d]: got valid=%b ready=%b busy=%b, required 0 1 0",
               d, rsp_valid[d], cmd_ready[d], busy[d]);
    end
  endtask

  task automatic check_reset_values(input int d, input string tag);
    vectors++;
    if (rsp_valid[d] !== 1'b0 || busy[d] !== 1'b0 || cmd_ready[d] !== 1'b1 ||
        flags[d] !== 3'b000 || rsp_s[d] !== 32'd0 || rsp_skip[d] !== 1'b0 ||
        alu_a[d] !== 32'd0 || alu_b[d] !== 32'd0 || alu_op[d] !== 4'd0) begin
      miscompares++;
      $display("FAIL %s[%0d]: got valid=%b busy=%b ready=%b flags=%b s=%h skip=%b a=%h b=%h op=%0d, required 0 0 1 000 0 0 0 0 0",
               tag, d, rsp_valid[d], busy[d], cmd_ready[d], flags[d], rsp_s[d],
               rsp_skip[d], alu_a[d], alu_b[d], alu_op[d]);
    end
  endtask

  task automatic test_reset(input int d);
    rst[d] = 1'b1;
    cmd_valid[d] = 1'b1;
    cmd_cond[d] = COND_AL;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values(d, "reset_state");
    cmd_valid[d] = 1'b0;
    rst[d] = 1'b0;
    mflags[d] = 3'b000; last_a[d] = 32'd0; last_op[d] = 4'd0;
    @(posedge clk); #1;
    check_reset_values(d, "after_release");
  endtask

  task automatic test_basic(input int d);
    send(d, OP_ADD, 32'd5, 32'hFFFF_FFFB, COND_AL, 1'b1); collect(d, 0);
    send(d, OP_ADD, 32'd7, 32'd1, COND_EQ, 1'b0);         collect(d, 0);
    send(d, OP_ADD, 32'd9, 32'd9, COND_NE, 1'b1);         collect(d, 0);
  endtask

  task automatic test_overflow(input int d);
    send(d, OP_ADD, 32'h7FFF_FFFF, 32'd1, COND_AL, 1'b1); collect(d, 0);
    send(d, OP_ADD, 32'd1, 32'd1, COND_AL, 1'b0);         collect(d, 0);
    send(d, OP_SUB, 32'd4, 32'd1, COND_MI, 1'b0);         collect(d, 0);
    send(d, OP_SUB, 32'd4, 32'd1, COND_VC, 1'b1);         collect(d, 0);
  endtask

  task automatic test_stall(input int d);
    send(d, OP_SUB, 32'd10, 32'd3, COND_AL, 1'b1);
    collect(d, 10);
  endtask

  task automatic test_reset_exec(input int d);
    exp_t dropped;
    send(d, OP_ADD, 32'h0000_1234, 32'd1, COND_AL, 1'b1);
    dropped = sb.pop_back();
    vectors++;
    if (busy[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL exec_busy[%0d]: got busy=%b valid=%b (s would be %h), required busy=1 valid=0",
               d, busy[d], rsp_valid[d], dropped.s);
    end
    rst[d] = 1'b1;
    #1;
    check_reset_values(d, "reset_mid_exec");
    cmd_valid[d] = 1'b1;
    @(posedge clk); #1;
    check_reset_values(d, "cmd_during_reset");
    cmd_valid[d] = 1'b0;
    rst[d] = 1'b0;
    mflags[d] = 3'b000; last_a[d] = 32'd0; last_op[d] = 4'd0;
    repeat (lat_of(d) + 3) begin
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL no_stale_rsp[%0d]: got rsp_valid=%b, required 0", d, rsp_valid[d]);
      end
    end
    send(d, OP_ADD, 32'd20, 32'd22, COND_PL, 1'b1); collect(d, 0);
  endtask

  task automatic test_never(input int d);
    send(d, OP_ADD, 32'd0, 32'd0, COND_AL, 1'b1); collect(d, 0);
    send(d, OP_SUB, 32'd0, 32'd1, COND_NV, 1'b1); collect(d, 0);
  endtask

  task automatic test_back_to_back(input int d);
    logic [31:0] avals [8];
    logic [2:0] c;
    avals = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFF0,
              32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd3};
    for (int i = 0; i < 8; i++) begin
      c = 3'(i);
      send(d, OP_ADD, avals[i], 32'd1, c, 1'b1); collect(d, 0);
      send(d, OP_SUB, avals[i], avals[i], c, (i % 2) == 0); collect(d, 0);
    end
    send(d, OP_AND, 32'h0000_00F0, 32'h0000_000F, COND_AL, 1'b1); collect(d, 0);
    send(d, OP_ADD, 32'd1, 32'd2, COND_EQ, 1'b1);                  collect(d, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_op[i] = '0; cmd_a[i] = '0; cmd_b[i] = '0;
      cmd_cond[i] = '0; cmd_setf[i] = 1'b0; rsp_ready[i] = 1'b0;
      mflags[i] = '0; last_a[i] = '0; last_op[i] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      test_reset(d);
      test_basic(d);
      test_overflow(d);
      test_stall(d);
      test_reset_exec(d);
      test_never(d);
      test_back_to_back(d);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
